// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use, branch and data-memory stall control for a 5-stage pipeline
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        exmem_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic [15:0] stall_count,
    output logic        mem_timeout
);

    typedef enum logic [1:0] {
        START    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Last MEM_WAIT count before the access is abandoned.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     nextState;
    logic [7:0] waitCnt;
    logic       clrWait;
    logic       incWait;
    logic       setTimeout;
    logic       loadUse;
    logic       branchFlush;

    // Hazard detection shared by RUN and the MEM_WAIT release cycle.
    always_comb begin
        loadUse     = idex_memread && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
        // A memory access and a taken branch together is illegal; the memory side wins.
        branchFlush = branch_taken && !dmem_req;
    end

    // Next-state and pipeline-control decode.
    always_comb begin
        nextState   = state;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        exmem_write = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        clrWait     = 1'b0;
        incWait     = 1'b0;
        setTimeout  = 1'b0;
        case (state)
            START: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_write = 1'b0;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                memwb_flush = 1'b1;
                nextState   = RUN;
            end
            RUN, MEM_WAIT: begin
                if ((state == RUN && dmem_req && !dmem_ready) ||
                    (state == MEM_WAIT && !dmem_ready && waitCnt != LAST_WAIT)) begin
                    // Freeze everything up to MEM; a bubble drains into WB.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_write  = 1'b0;
                    exmem_write = 1'b0;
                    memwb_flush = 1'b1;
                    nextState   = MEM_WAIT;
                    clrWait     = (state == RUN);
                    incWait     = (state == MEM_WAIT);
                end else if (state == MEM_WAIT && !dmem_ready) begin
                    // Abort: let the pipeline move on with a bubble in place of the load result.
                    memwb_flush = 1'b1;
                    setTimeout  = 1'b1;
                    clrWait     = 1'b1;
                    nextState   = RUN;
                end else begin
                    if (branchFlush) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (loadUse) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                    clrWait   = (state == MEM_WAIT);
                    nextState = RUN;
                end
            end
            default: nextState = START;
        endcase
    end

    // State, wait counter, stall statistics and sticky abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= START;
            waitCnt     <= 8'd0;
            stall_count <= 16'd0;
            mem_timeout <= 1'b0;
        end else begin
            state <= nextState;
            if (clrWait) begin
                waitCnt <= 8'd0;
            end else if (incWait) begin
                waitCnt <= waitCnt + 8'd1;
            end
            if (state != START && !pc_write && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
            if (setTimeout) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        idex_memread;
    logic [4:0]  idex_rt;
    logic [4:0]  ifid_rs;
    logic [4:0]  ifid_rt;
    logic        branch_taken;
    logic        dmem_req;
    logic        dmem_ready;
    logic        pc_write, ifid_write, idex_write, exmem_write;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [15:0] stall_count;
    logic        mem_timeout;
    logic [7:0]  outs;

    int applied = 0;
    int miscompares = 0;
    logic [15:0] expStall = 16'd0;

    // {pc, ifid, idex, exmem write, ifid, idex, exmem, memwb flush}
    localparam logic [7:0] O_START  = 8'b0000_1111;
    localparam logic [7:0] O_IDLE   = 8'b1111_0000;
    localparam logic [7:0] O_LDUSE  = 8'b0011_0100;
    localparam logic [7:0] O_BRANCH = 8'b1111_1110;
    localparam logic [7:0] O_FREEZE = 8'b0000_0001;
    localparam logic [7:0] O_ABORT  = 8'b1111_0001;

    typedef struct {
        logic       memread;
        logic [4:0] rt;
        logic [4:0] rs;
        logic [4:0] rt2;
        logic       br;
        logic       req;
        logic       rdy;
        logic [7:0] expOuts;
        logic       stallInc;
    } vec_t;

    vec_t vecs [10];

    pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .idex_memread(idex_memread), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write), .exmem_write(exmem_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .stall_count(stall_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    assign outs = {pc_write, ifid_write, idex_write, exmem_write,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                         input logic [4:0] rt2, input logic br, input logic req, input logic rdy);
        idex_memread = mr;
        idex_rt      = rt;
        ifid_rs      = rs;
        ifid_rt      = rt2;
        branch_taken = br;
        dmem_req     = req;
        dmem_ready   = rdy;
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE,   1'b0};
        vecs[1] = '{1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, O_LDUSE,  1'b1};
        vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_IDLE,   1'b0};
        vecs[3] = '{1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, O_LDUSE,  1'b1};
        vecs[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, O_IDLE,   1'b0};
        vecs[5] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, O_BRANCH, 1'b0};
        vecs[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, O_BRANCH, 1'b0};
        vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, O_IDLE,   1'b0};
        vecs[8] = '{1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, O_LDUSE,  1'b1};
        vecs[9] = '{1'b1, 5'd3, 5'd4, 5'd6, 1'b0, 1'b0, 1'b0, O_IDLE,   1'b0};

        // Reset and the single START cycle.
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset_outs", 16'(outs), 16'(O_START));
        chk("reset_stall", stall_count, 16'd0);
        chk("reset_timeout", 16'(mem_timeout), 16'd0);
        step();
        rst = 1'b0;
        #2;
        chk("start_outs", 16'(outs), 16'(O_START));
        step();
        #2;
        chk("run_outs", 16'(outs), 16'(O_IDLE));
        chk("start_no_count", stall_count, 16'd0);

        // Single-cycle RUN vectors.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].memread, vecs[i].rt, vecs[i].rs, vecs[i].rt2,
                  vecs[i].br, vecs[i].req, vecs[i].rdy);
            #2;
            chk($sformatf("vec%0d_outs", i), 16'(outs), 16'(vecs[i].expOuts));
            step();
            if (vecs[i].stallInc) expStall = expStall + 16'd1;
            chk($sformatf("vec%0d_stall", i), stall_count, expStall);
        end

        // Memory wait: three frozen cycles then release.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk($sformatf("memwait_freeze%0d", k), 16'(outs), 16'(O_FREEZE));
            step();
        end
        dmem_ready = 1'b1;
        #2;
        chk("memwait_release", 16'(outs), 16'(O_IDLE));
        step();
        expStall = expStall + 16'd3;
        chk("memwait_stall", stall_count, expStall);
        chk("memwait_timeout", 16'(mem_timeout), 16'd0);

        // Timeout: four frozen cycles, abort on the fifth.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #2;
            chk($sformatf("timeout_freeze%0d", k), 16'(outs), 16'(O_FREEZE));
            step();
        end
        #2;
        chk("timeout_abort", 16'(outs), 16'(O_ABORT));
        step();
        dmem_req = 1'b0;
        expStall = expStall + 16'd4;
        chk("timeout_stall", stall_count, expStall);
        chk("timeout_flag", 16'(mem_timeout), 16'd1);
        #2;
        chk("after_abort_run", 16'(outs), 16'(O_IDLE));
        for (int k = 0; k < 3; k++) step();
        chk("timeout_sticky", 16'(mem_timeout), 16'd1);

        // Asynchronous reset in the middle of MEM_WAIT.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        #2;
        chk("pre_reset_freeze", 16'(outs), 16'(O_FREEZE));
        rst = 1'b1;
        #1;
        chk("async_reset_outs", 16'(outs), 16'(O_START));
        chk("async_reset_stall", stall_count, 16'd0);
        chk("async_reset_timeout", 16'(mem_timeout), 16'd0);
        dmem_req = 1'b0;
        step();
        rst = 1'b0;
        #2;
        chk("rerelease_start", 16'(outs), 16'(O_START));
        step();
        #2;
        chk("rerelease_run", 16'(outs), 16'(O_IDLE));
        chk("rerelease_stall", stall_count, 16'd0);
        chk("rerelease_timeout", 16'(mem_timeout), 16'd0);

        // Saturation under a held load-use hazard.
        drive(1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (70000) step();
        chk("sat_outs", 16'(outs), 16'(O_LDUSE));
        chk("sat_value", stall_count, 16'hFFFF);
        repeat (5) step();
        chk("sat_hold", stall_count, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL provide parameter: TIMEOUT, 255, max stall cycles per data-memory access before abort (2..255).
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- idex_memread  in  1  ID/EX holds a load
- idex_rt  in  5  ID/EX load destination
- ifid_rs, ifid_rt  in  5 each  IF/ID source registers
- branch_taken  in  1  EX/MEM pcSrc, branch resolved taken
- dmem_req  in  1  EX/MEM holds a memory access
- dmem_ready  in  1  data memory completes access this cycle
- pc_write, ifid_write, idex_write, exmem_write  out  1 each  register load enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous bubble insert; overrides write in target register
- stall_count  out  16  saturating stall-cycle counter
- mem_timeout  out  1  sticky memory-abort flag

Function
REQ-003 SHALL implement FSM states START, RUN, MEM_WAIT; outputs are decoded combinationally from state and inputs, counters registered.
REQ-004 START SHALL last exactly one cycle: pc_write=0, all writes=0, all flushes=1; next state RUN.
REQ-005 RUN default SHALL be all writes=1, all flushes=0.
REQ-006 Load-use in RUN: idex_memread=1, idex_rt!=0, idex_rt equals ifid_rs or ifid_rt -> pc_write=0, ifid_write=0, idex_flush=1, exmem/memwb normal; one cycle, no state change.
REQ-007 idex_rt=0 SHALL never cause a load-use stall.
REQ-008 Branch in RUN: branch_taken=1 -> pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1; overrides a simultaneous load-use stall.
REQ-009 Memory stall entry in RUN: dmem_req=1, dmem_ready=0 -> pc_write, ifid_write, idex_write, exmem_write all 0, memwb_flush=1, wait_cnt cleared, next state MEM_WAIT.
REQ-010 dmem_req=1 with branch_taken=1 is illegal; dmem handling SHALL take priority and the branch flush SHALL be suppressed.
REQ-011 MEM_WAIT with dmem_ready=0 and wait_cnt<TIMEOUT-1: same freeze as REQ-009, wait_cnt increments; load-use and branch inputs ignored.
REQ-012 MEM_WAIT with dmem_ready=1 (release): writes/flushes per RUN rules including REQ-006 evaluated that cycle; next state RUN.
REQ-013 MEM_WAIT with dmem_ready=0 and wait_cnt=TIMEOUT-1 (abort): all writes=1, memwb_flush=1, mem_timeout set, next state RUN, wait_cnt cleared.
REQ-014 Total frozen cycles per access SHALL therefore be at most TIMEOUT (entry cycle plus TIMEOUT-1 MEM_WAIT cycles).
REQ-015 dmem_req=1 with dmem_ready=1 in RUN SHALL cause no stall.
REQ-016 stall_count SHALL increment by 1 on each cycle with pc_write=0 in RUN or MEM_WAIT (not START); saturates at 0xFFFF.
REQ-017 mem_timeout SHALL remain 1 until reset.

Reset
REQ-018 rst=1 SHALL immediately, independent of clk, force state=START, wait_cnt=0, stall_count=0, mem_timeout=0, outputs per REQ-004.
REQ-019 On rst deassertion SHALL spend one START cycle then enter RUN; reset during MEM_WAIT abandons the access without setting mem_timeout.

Verification
REQ-020 Reset: assert rst mid-MEM_WAIT -> outputs per REQ-004 same cycle, stall_count=0; release -> one START cycle, then RUN with all writes=1.
REQ-021 Load-use: idex_memread=1, idex_rt=5, ifid_rs=5 -> one cycle pc_write=0, ifid_write=0, idex_flush=1, stall_count=1; repeat with idex_rt=0 -> no stall.
REQ-022 Memory wait: dmem_req=1, dmem_ready=0 three cycles then 1 -> three frozen cycles with memwb_flush=1, release on fourth, stall_count +3, mem_timeout=0.
REQ-023 Branch priority: branch_taken=1 with load-use hazard -> pc_write=1, ifid/idex/exmem_flush=1, stall_count unchanged.
REQ-024 Timeout: TIMEOUT=4, dmem_ready held 0 -> four frozen cycles, abort on fifth (writes=1, memwb_flush=1), mem_timeout=1 and stays 1.
REQ-025 Saturation: 70000 consecutive stall cycles -> stall_count=0xFFFF, no wrap.
